// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared types and encodings for the multicycle controller
// Purpose: state enum, opcode constants, ALU_control / ImmSrc codes and the
//          ImmSrc decode helper shared by the controller, its ALU decoder and
//          its interface.
// Ports:   none (package).
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  // Which kind of ALU operation the current state asks for.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_class_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    logic [1:0] r;
    case (op)
      OP_LW, OP_I: r = IMM_I;
      OP_SW:       r = IMM_S;
      OP_BEQ:      r = IMM_B;
      OP_JAL:      r = IMM_J;
      default:     r = IMM_I;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath signal bundle
// Purpose: groups the instruction fields, status inputs and control outputs.
// Ports:   master = controller side (drives controls, reads op/flags);
//          slave  = datapath side (drives op/flags, reads controls).
interface multicycle_controller_if;

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero_flag;
  logic        mem_ready;

  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALU_control;
  logic        illegal;
  logic [31:0] instret;

  modport master (
    input  op, funct3, funct7b5, Zero_flag, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALU_control, illegal, instret
  );

  modport slave (
    output op, funct3, funct7b5, Zero_flag, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALU_control, illegal, instret
  );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - combinational ALU_control decode
// Purpose: maps the state's ALU class plus funct3/funct7b5/op[5] to ALU_control.
// Ports:   alu_class_i  - ADD, SUB or FUNCT (decode from funct fields)
//          funct3_i     - instr[14:12]
//          funct7b5_i   - instr[30]
//          op5_i        - op[5], 1 for R-type, 0 for I-type ALU ops
//          alu_control_o- ALU operation code
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_class_e  alu_class_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic        op5_i,
  output logic [2:0]  alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_class_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // funct7b5 only selects sub for R-type; for addi it is immediate bits.
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32 subset control FSM with retire counter
// Purpose: sequences FETCH/DECODE/execute states for lw, sw, R, I, beq, jal,
//          drives datapath controls and counts retired instructions.
// Ports:   clk   - rising-edge clock
//          reset - synchronous active-high reset
//          bus   - master side of multicycle_controller_if (op/funct/flags in,
//                  datapath controls, illegal and instret out)
// Param:   MEM_HANDSHAKE - 1: memory states wait for mem_ready; 0: single cycle
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;

  logic        mem_done;
  logic        retire;

  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal_st;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  alu_class_e  alu_class;
  logic [2:0]  alu_control;

  assign mem_done = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // State register and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      // Only lw/sw reach MEMADR and op is stable, so not-lw means sw.
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_done ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_done ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // JAL retires through ALUWB, so counting the exits to FETCH counts it once.
  assign retire = (state_d == S_FETCH) &&
                  (state_q == S_MEMWB || state_q == S_MEMWRITE ||
                   state_q == S_ALUWB || state_q == S_BEQ);
  assign instret_d = retire ? instret_q + 32'd1 : instret_q;

  // Output logic.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal_st = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_class  = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_class = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_class = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_class = ALUOP_SUB;
        pc_write  = bus.Zero_flag;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_ILLEGAL:  illegal_st = 1'b1;
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class_i   (alu_class),
    .funct3_i      (bus.funct3),
    .funct7b5_i    (bus.funct7b5),
    .op5_i         (bus.op[5]),
    .alu_control_o (alu_control)
  );

  // Enables are masked during reset: the state register may still hold
  // FETCH or a memory state for the reset cycle itself.
  assign bus.PCWrite     = pc_write   & ~reset;
  assign bus.IRWrite     = ir_write   & ~reset;
  assign bus.MemWrite    = mem_write  & ~reset;
  assign bus.RegWrite    = reg_write  & ~reset;
  assign bus.illegal     = illegal_st & ~reset;
  assign bus.AdrSrc      = adr_src;
  assign bus.ResultSrc   = result_src;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALU_control = alu_control;
  assign bus.ImmSrc      = imm_src(bus.op);
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  typedef struct packed {
    logic        pcw;
    logic        adr;
    logic        memw;
    logic        irw;
    logic        regw;
    logic [1:0]  res;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [1:0]  imm;
    logic [2:0]  alu;
    logic        ill;
    logic [31:0] ir;
  } ctl_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ctl_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned retired = 0;

  function automatic logic [6:0] op_of(input int k);
    case (k)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BEQ:   return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_of(input bit is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctl_t c_fetch();
    ctl_t c = '0;
    c.pcw = 1'b1; c.irw = 1'b1; c.sb = 2'b10; c.res = 2'b10;
    return c;
  endfunction
  function automatic ctl_t c_decode();
    ctl_t c = '0;
    c.sa = 2'b01; c.sb = 2'b01;
    return c;
  endfunction
  function automatic ctl_t c_memadr();
    ctl_t c = '0;
    c.sa = 2'b10; c.sb = 2'b01;
    return c;
  endfunction
  function automatic ctl_t c_memread();
    ctl_t c = '0;
    c.adr = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_memwb();
    ctl_t c = '0;
    c.res = 2'b01; c.regw = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_memwrite();
    ctl_t c = '0;
    c.adr = 1'b1; c.memw = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_exec(input bit is_r, input logic [2:0] alu);
    ctl_t c = '0;
    c.sa = 2'b10; c.sb = is_r ? 2'b00 : 2'b01; c.alu = alu;
    return c;
  endfunction
  function automatic ctl_t c_aluwb();
    ctl_t c = '0;
    c.regw = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_beq(input logic z);
    ctl_t c = '0;
    c.sa = 2'b10; c.alu = 3'b001; c.pcw = z;
    return c;
  endfunction
  function automatic ctl_t c_jal();
    ctl_t c = '0;
    c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_illegal();
    ctl_t c = '0;
    c.ill = 1'b1;
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs, queue what the outputs must be this cycle.
  task automatic step(input ctl_t e, input logic mr, input logic zf, input logic rst);
    reset         = rst;
    bus.mem_ready = mr;
    bus.Zero_flag = zf;
    e.imm = imm_of(bus.op);
    e.ir  = retired;
    if (rst) begin
      e.pcw = 1'b0; e.irw = 1'b0; e.memw = 1'b0; e.regw = 1'b0; e.ill = 1'b0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int k, input logic [2:0] f3, input logic f7,
                           input logic z, input int waits);
    bus.op       = op_of(k);
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    step(c_fetch(), rb(), rb(), 1'b0);
    step(c_decode(), rb(), rb(), 1'b0);
    case (k)
      K_LW: begin
        step(c_memadr(), rb(), rb(), 1'b0);
        repeat (waits) step(c_memread(), 1'b0, rb(), 1'b0);
        step(c_memread(), 1'b1, rb(), 1'b0);
        step(c_memwb(), rb(), rb(), 1'b0);
      end
      K_SW: begin
        step(c_memadr(), rb(), rb(), 1'b0);
        repeat (waits) step(c_memwrite(), 1'b0, rb(), 1'b0);
        step(c_memwrite(), 1'b1, rb(), 1'b0);
      end
      K_R, K_I: begin
        step(c_exec(k == K_R, alu_of(k == K_R, f3, f7)), rb(), rb(), 1'b0);
        step(c_aluwb(), rb(), rb(), 1'b0);
      end
      K_BEQ: step(c_beq(z), rb(), z, 1'b0);
      default: begin
        step(c_jal(), rb(), rb(), 1'b0);
        step(c_aluwb(), rb(), rb(), 1'b0);
      end
    endcase
    retired = retired + 1;
  endtask

  // Monitor: every cycle with a queued expectation is compared at negedge.
  always @(negedge clk) begin
    ctl_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.pcw = bus.PCWrite;   a.adr = bus.AdrSrc;   a.memw = bus.MemWrite;
      a.irw = bus.IRWrite;   a.regw = bus.RegWrite; a.res = bus.ResultSrc;
      a.sa  = bus.ALUSrcA;   a.sb = bus.ALUSrcB;   a.imm = bus.ImmSrc;
      a.alu = bus.ALU_control; a.ill = bus.illegal; a.ir = bus.instret;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL ctl_word t=%0t actual=%h required=%h", $time, a, e);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.op        = 7'b0110011;
    bus.funct3    = 3'b000;
    bus.funct7b5  = 1'b0;
    bus.mem_ready = 1'b0;
    bus.Zero_flag = 1'b0;
    @(posedge clk);
    #1;
    // Second reset cycle: state is FETCH but all enables must be masked.
    step(c_fetch(), 1'b0, 1'b0, 1'b1);

    run_instr(K_R,   3'b000, 1'b0, 1'b0, 0);   // add
    run_instr(K_R,   3'b000, 1'b1, 1'b0, 0);   // sub
    run_instr(K_I,   3'b000, 1'b1, 1'b0, 0);   // addi, funct7b5 ignored
    run_instr(K_LW,  3'b010, 1'b0, 1'b0, 3);   // lw with 3 wait cycles
    run_instr(K_BEQ, 3'b000, 1'b0, 1'b1, 0);
    run_instr(K_BEQ, 3'b000, 1'b0, 1'b0, 0);
    run_instr(K_SW,  3'b010, 1'b0, 1'b0, 0);
    run_instr(K_JAL, 3'b000, 1'b0, 1'b0, 0);
    run_instr(K_R,   3'b111, 1'b0, 1'b0, 0);
    run_instr(K_I,   3'b110, 1'b0, 1'b0, 0);
    run_instr(K_R,   3'b010, 1'b1, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      run_instr(int'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), rb(), rb(),
                int'($urandom_range(0, 3)));
    end

    // Illegal opcode: held 10 cycles, then reset clears it and instret.
    bus.op = 7'b0000000;
    step(c_fetch(), rb(), rb(), 1'b0);
    step(c_decode(), rb(), rb(), 1'b0);
    repeat (10) step(c_illegal(), rb(), rb(), 1'b0);
    step(c_illegal(), rb(), rb(), 1'b1);
    retired = 0;
    run_instr(K_R, 3'b000, 1'b0, 1'b0, 0);

    // sw interrupted by reset mid-wait.
    bus.op = 7'b0100011;
    step(c_fetch(), rb(), rb(), 1'b0);
    step(c_decode(), rb(), rb(), 1'b0);
    step(c_memadr(), rb(), rb(), 1'b0);
    repeat (2) step(c_memwrite(), 1'b0, rb(), 1'b0);
    step(c_memwrite(), 1'b0, rb(), 1'b1);
    retired = 0;
    run_instr(K_LW, 3'b010, 1'b0, 1'b0, 1);
    run_instr(K_BEQ, 3'b000, 1'b0, 1'b1, 0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1, meaning: 1 = MEMREAD/MEMWRITE wait for mem_ready; 0 = both states complete in one cycle and mem_ready is ignored.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  7  opcode, instr[6:0] of the instruction register.
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 Zero_flag  input  1  ALU zero result.
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 PCWrite  output  1  PC register enable.
REQ-010 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-011 MemWrite  output  1  data memory write strobe.
REQ-012 IRWrite  output  1  instruction register and old-PC register enable.
REQ-013 RegWrite  output  1  register file write enable.
REQ-014 ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result.
REQ-015 ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-016 ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
REQ-017 ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-018 ALU_control  output  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
REQ-019 illegal  output  1  high while in ILLEGAL.
REQ-020 instret  output  32  retired-instruction count.

Function
REQ-021 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL; the state register updates every clock edge.
REQ-022 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALU_control=add, ResultSrc=10, PCWrite=1; next state DECODE.
REQ-023 DECODE: ALUSrcA=01, ALUSrcB=01, ALU_control=add, computing the branch target.
REQ-024 DECODE next state by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BEQ, 1101111 -> JAL, any other value -> ILLEGAL.
REQ-025 MEMADR: ALUSrcA=10, ALUSrcB=01, ALU_control=add; next state MEMREAD for lw, MEMWRITE for sw.
REQ-026 MEMREAD: AdrSrc=1, ResultSrc=00; advances to MEMWB when mem_ready=1, otherwise holds.
REQ-027 MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-028 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, with MemWrite held high for every wait cycle; advances to FETCH when mem_ready=1, otherwise holds.
REQ-029 EXECUTER: ALUSrcA=10, ALUSrcB=00; EXECUTEI: ALUSrcA=10, ALUSrcB=01; both use the decoded ALU_control and go next to ALUWB.
REQ-030 ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
REQ-031 BEQ: ALUSrcA=10, ALUSrcB=00, ALU_control=sub, ResultSrc=00, PCWrite=Zero_flag (combinational, same cycle); next state FETCH.
REQ-032 JAL: ALUSrcA=01, ALUSrcB=10, ALU_control=add, ResultSrc=00, PCWrite=1; next state ALUWB.
REQ-033 ILLEGAL: all enables 0 and illegal=1; the state is held until reset.
REQ-034 Any output not listed for a state SHALL be 0.
REQ-035 ImmSrc is decoded from op in every state: lw/I-type -> 00, sw -> 01, beq -> 10, jal -> 11, otherwise 00.
REQ-036 ALU_control decode for EXECUTER/EXECUTEI by funct3:
- 000: sub only when R-type with funct7b5=1, otherwise add.
- 010: slt.
- 110: or.
- 111: and.
- Any other funct3: add.
REQ-037 instret increments by 1, wrapping modulo 2^32, on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; the JAL -> ALUWB -> FETCH path counts exactly once.
REQ-038 Latency in cycles: lw 5, sw 4, R/I 4, beq 3, jal 4; each mem_ready=0 cycle adds one cycle when MEM_HANDSHAKE=1.

Reset
REQ-039 reset=1 at a clock edge forces state FETCH and instret=0 from any state, including mid-wait and ILLEGAL.
REQ-040 While reset is asserted, all enables (PCWrite, IRWrite, MemWrite, RegWrite) SHALL be 0 and illegal=0.
REQ-041 The first cycle after reset deasserts is a FETCH cycle.

Structure
REQ-042 A shared package holds the state enum, the opcode constants (lw, sw, R, I, beq, jal), the ALU_control codes and the ImmSrc codes.
REQ-043 One sub-module, alu_decoder, combinationally maps (state class, funct3, funct7b5, op[5]) to ALU_control; the FSM and instret live in multicycle_controller.

Verification
REQ-044 add x3,x1,x2 (op 0110011, funct3 000, funct7b5 0) -> states FETCH, DECODE, EXECUTER, ALUWB; ALU_control=000 in EXECUTER; RegWrite=1 for exactly 1 cycle; instret 0 -> 1.
REQ-045 sub variant (funct7b5=1) -> ALU_control=001 in EXECUTER; addi (op 0010011) with funct7b5=1 -> ALU_control=000.
REQ-046 lw with mem_ready=0 for 3 cycles -> MEMREAD held 3 extra cycles, RegWrite pulses in MEMWB; 8 cycles total from FETCH to the next FETCH.
REQ-047 beq -> with Zero_flag=1, PCWrite=1 in the BEQ cycle; with Zero_flag=0, PCWrite=0; either way the return to FETCH follows 3 cycles after FETCH.
REQ-048 op=0000000 -> ILLEGAL entered after DECODE, illegal=1 held for 10 cycles with no enables; reset then returns to FETCH with instret=0.
REQ-049 sw with reset asserted during the MEMWRITE wait -> next cycle FETCH, MemWrite=0, instret=0.
